// File: rtl/graph_px_scheduler.sv
// ---------------------------------------------------------------------------
// graph_px_scheduler
//
// Keeps a 64-deep circular history of five sensor channels (humidity,
// temperature, magnetometer X/Y/Z) and answers per-pixel lookups for a
// 64-column by 128-row strip-chart display.
//
// Ingest side: a two-state FSM (IDLE/COMMIT) accepts one sample set per
// handshake, latches it, and writes it into the history on the following
// cycle. freeze blocks new samples, clear empties the history.
//
// Lookup side: a fixed-latency pipeline. A request sampled at edge N shows
// its answer on px_valid/px_code after edge N+2, one request per cycle,
// no back-pressure.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   sample_valid/ready    sample set handshake
//   s_hum..s_magz [7:0]   unsigned samples, stored as sample >> 1
//   ch_en [4:0]           channel enables (0 hum,1 temp,2 magx,3 magy,4 magz)
//   freeze                hold display, refuse new samples
//   clear                 synchronous history clear
//   px_req, px_col, px_row  pixel lookup request (col 0 = left, row 0 = top)
//   px_valid, px_code     lookup answer: bits 0..4 channel hits, bit 5 grid
//   count [6:0]           number of stored sample sets, 0..64
// ---------------------------------------------------------------------------
module graph_px_scheduler (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sample_valid,
   output logic       sample_ready,
   input  logic [7:0] s_hum,
   input  logic [7:0] s_temp,
   input  logic [7:0] s_magx,
   input  logic [7:0] s_magy,
   input  logic [7:0] s_magz,
   input  logic [4:0] ch_en,
   input  logic       freeze,
   input  logic       clear,
   input  logic       px_req,
   input  logic [5:0] px_col,
   input  logic [6:0] px_row,
   output logic       px_valid,
   output logic [5:0] px_code,
   output logic [6:0] count
);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      COMMIT = 1'b1
   } ingest_state_e;

   ingest_state_e state_q;
   ingest_state_e state_d;

   logic        accept;
   logic        commit_en;
   logic [5:0]  wr_ptr;

   logic [6:0]  lat_hum;
   logic [6:0]  lat_temp;
   logic [6:0]  lat_magx;
   logic [6:0]  lat_magy;
   logic [6:0]  lat_magz;

   logic [34:0] hist_mem [64];

   logic [5:0]  rd_idx;
   logic        rd_populated;

   logic        s1_valid;
   logic [6:0]  s1_row;
   logic [4:0]  s1_en;
   logic        s1_populated;
   logic [34:0] s1_entry;

   logic [5:0]  hit_code;
   logic        s2_valid;
   logic [5:0]  s2_code;

   // The LSB of every sample is dropped by the >>1 scaling.
   logic        unused_lsbs;
   assign unused_lsbs = ^{s_hum[0], s_temp[0], s_magx[0], s_magy[0], s_magz[0]};

   // Ingest FSM next-state and handshake. Ready is also gated by rst_n so it
   // reads 0 for the whole time reset is held. clear wins over everything:
   // it blocks acceptance and turns a pending commit into a no-op.
   always_comb begin
      state_d      = state_q;
      sample_ready = 1'b0;
      accept       = 1'b0;
      commit_en    = 1'b0;
      case (state_q)
         IDLE: begin
            sample_ready = rst_n & ~freeze & ~clear;
            accept       = sample_valid & rst_n & ~freeze & ~clear;
            if (accept) begin
               state_d = COMMIT;
            end
         end
         COMMIT: begin
            commit_en = ~clear;
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (clear) begin
         state_d = IDLE;
      end
   end

   // FSM state, write pointer and occupancy. Once count reaches 64 the write
   // pointer keeps advancing, so every commit overwrites the oldest entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         wr_ptr  <= 6'd0;
         count   <= 7'd0;
      end else begin
         state_q <= state_d;
         if (clear) begin
            wr_ptr <= 6'd0;
            count  <= 7'd0;
         end else if (commit_en) begin
            wr_ptr <= wr_ptr + 6'd1;
            if (count != 7'd64) begin
               count <= count + 7'd1;
            end
         end
      end
   end

   // Sample holding registers, loaded on the accepting edge and already
   // scaled to the 7-bit stored form.
   always_ff @(posedge clk) begin
      if (accept) begin
         lat_hum  <= s_hum[7:1];
         lat_temp <= s_temp[7:1];
         lat_magx <= s_magx[7:1];
         lat_magy <= s_magy[7:1];
         lat_magz <= s_magz[7:1];
      end
   end

   // History storage. Contents are never reset; count = 0 hides stale data.
   always_ff @(posedge clk) begin
      if (commit_en) begin
         hist_mem[wr_ptr] <= {lat_magz, lat_magy, lat_magx, lat_temp, lat_hum};
      end
   end

   // Column to entry mapping. While the history is filling, column c is
   // entry c; once full, the oldest entry (at wr_ptr) sits in column 0 and
   // the 6-bit add wraps naturally.
   always_comb begin
      rd_idx       = px_col;
      rd_populated = ({1'b0, px_col} < count);
      if (count == 7'd64) begin
         rd_idx = wr_ptr + px_col;
      end
   end

   // Stage 1 data: the history is read on the same edge that samples the
   // request, so a commit landing on that edge is not seen by it.
   always_ff @(posedge clk) begin
      s1_row       <= px_row;
      s1_en        <= ch_en;
      s1_populated <= rd_populated;
      s1_entry     <= hist_mem[rd_idx];
   end

   // Pixel classification: a channel hits when its plotted row
   // (127 - value) equals the requested row; bit 5 draws grid lines every
   // 32 rows plus the baseline at the bottom.
   always_comb begin
      hit_code = 6'd0;
      for (int k = 0; k < 5; k++) begin
         hit_code[k] = s1_populated & s1_en[k] &
                       (s1_row == (7'd127 - s1_entry[k*7 +: 7]));
      end
      hit_code[5] = (s1_row[4:0] == 5'd0) | (s1_row == 7'd127);
   end

   // Pipeline valid flags and code registers. Codes are zeroed whenever the
   // slot is empty so px_code is 0 whenever px_valid is 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         s2_code  <= 6'd0;
         px_valid <= 1'b0;
         px_code  <= 6'd0;
      end else begin
         s1_valid <= px_req;
         s2_valid <= s1_valid;
         s2_code  <= s1_valid ? hit_code : 6'd0;
         px_valid <= s2_valid;
         px_code  <= s2_valid ? s2_code : 6'd0;
      end
   end

endmodule

// File: tb/tb_graph_px_scheduler.sv
// ---------------------------------------------------------------------------
// tb_graph_px_scheduler
//
// Directed bench for graph_px_scheduler. Pixel requests push their expected
// code and due cycle into a scoreboard queue; an independent monitor pops
// and compares whenever px_valid is seen. Handshake and count checks are
// made directly from the stimulus thread.
// ---------------------------------------------------------------------------
module tb_graph_px_scheduler;

   logic       clk;
   logic       rst_n;
   logic       sample_valid;
   logic       sample_ready;
   logic [7:0] s_hum;
   logic [7:0] s_temp;
   logic [7:0] s_magx;
   logic [7:0] s_magy;
   logic [7:0] s_magz;
   logic [4:0] ch_en;
   logic       freeze;
   logic       clear;
   logic       px_req;
   logic [5:0] px_col;
   logic [6:0] px_row;
   logic       px_valid;
   logic [5:0] px_code;
   logic [6:0] count;

   typedef struct {
      logic [5:0] code;
      int         due;
      string      name;
   } exp_t;

   exp_t sb[$];
   int   cyc;
   int   checks;
   int   errors;

   graph_px_scheduler dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .s_hum        (s_hum),
      .s_temp       (s_temp),
      .s_magx       (s_magx),
      .s_magy       (s_magy),
      .s_magz       (s_magz),
      .ch_en        (ch_en),
      .freeze       (freeze),
      .clear        (clear),
      .px_req       (px_req),
      .px_col       (px_col),
      .px_row       (px_row),
      .px_valid     (px_valid),
      .px_code      (px_code),
      .count        (count)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edge counter used to timestamp requests and responses
   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input int actual, input int required);
      checks++;
      if (actual !== required) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
      end
   endtask

   // Must be called at a negedge; drives one request cycle and returns at
   // the next negedge so consecutive calls are back-to-back.
   task automatic applyStimulus(input string name, input int col, input int row,
                                input logic [4:0] en, input logic [5:0] exp_code);
      exp_t e;
      px_req = 1'b1;
      px_col = col[5:0];
      px_row = row[6:0];
      ch_en  = en;
      e.code = exp_code;
      e.due  = cyc + 3;
      e.name = name;
      sb.push_back(e);
      @(negedge clk);
   endtask

   // Push one sample set through the handshake; starts and ends at a negedge,
   // returning once the commit edge has passed.
   task automatic pushSet(input int h, input int t, input int x, input int y, input int z);
      int guard;
      s_hum  = h[7:0];
      s_temp = t[7:0];
      s_magx = x[7:0];
      s_magy = y[7:0];
      s_magz = z[7:0];
      sample_valid = 1'b1;
      guard = 0;
      while (!sample_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 20) checkOutput("push_ready_timeout", 0, 1);
      @(negedge clk);
      sample_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic drain();
      int guard;
      px_req = 1'b0;
      guard = 0;
      while (sb.size() > 0 && guard < 10) begin
         @(negedge clk);
         guard++;
      end
      if (sb.size() > 0) begin
         checkOutput("drain_timeout", sb.size(), 0);
         sb.delete();
      end
   endtask

   // Monitor: compares every presented response against the scoreboard head,
   // and flags any expected response whose due cycle passes unseen.
   always @(negedge clk) begin
      exp_t e;
      if (px_valid) begin
         if (sb.size() == 0) begin
            checkOutput("px_unexpected_valid", 1, 0);
         end else begin
            e = sb.pop_front();
            checkOutput({e.name, "_code"}, px_code, e.code);
            checkOutput({e.name, "_latency"}, cyc, e.due);
         end
      end else begin
         checkOutput("px_code_idle_zero", px_code, 0);
         if (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            checkOutput({e.name, "_missing"}, 0, 1);
         end
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      sample_valid = 1'b0;
      s_hum = 8'd0; s_temp = 8'd0; s_magx = 8'd0; s_magy = 8'd0; s_magz = 8'd0;
      ch_en = 5'd0; freeze = 1'b0; clear = 1'b0;
      px_req = 1'b0; px_col = 6'd0; px_row = 7'd0;

      // Reset state
      #1;
      checkOutput("rst_px_valid", px_valid, 0);
      checkOutput("rst_px_code", px_code, 0);
      checkOutput("rst_ready", sample_ready, 0);
      checkOutput("rst_count", count, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1 checkOutput("ready_after_reset", sample_ready, 1);

      // Empty history: only grid bits
      @(negedge clk);
      applyStimulus("empty_r32", 0, 32, 5'b11111, 6'b100000);
      applyStimulus("empty_r10", 0, 10, 5'b11111, 6'b000000);
      applyStimulus("empty_r127", 0, 127, 5'b11111, 6'b100000);
      drain();

      // Single set: hum 200 -> 100 -> row 27, temp 100 -> 50 -> row 77
      pushSet(200, 100, 0, 0, 0);
      checkOutput("count_one", count, 1);
      applyStimulus("one_hum", 0, 27, 5'b11111, 6'b000001);
      applyStimulus("one_temp", 0, 77, 5'b11111, 6'b000010);
      applyStimulus("one_col1", 1, 77, 5'b11111, 6'b000000);
      applyStimulus("one_base", 0, 127, 5'b11111, 6'b111100);
      applyStimulus("one_masked", 0, 27, 5'b11110, 6'b000000);
      applyStimulus("one_col1_base", 1, 127, 5'b11111, 6'b100000);
      drain();

      // Continuous sample_valid: ready alternates, 4 sets in 8 cycles
      s_hum = 8'd20; s_temp = 8'd40; s_magx = 8'd60; s_magy = 8'd80; s_magz = 8'd100;
      sample_valid = 1'b1;
      for (int j = 0; j < 8; j++) begin
         if (j > 0) @(negedge clk);
         checkOutput("ready_alternate", sample_ready, (j % 2 == 0) ? 1 : 0);
      end
      @(negedge clk);
      sample_valid = 1'b0;
      checkOutput("count_stream", count, 5);
      applyStimulus("stream_hum", 4, 117, 5'b00001, 6'b000001);
      applyStimulus("stream_magz", 4, 77, 5'b10000, 6'b010000);
      applyStimulus("stream_temp", 3, 107, 5'b00010, 6'b000010);
      drain();

      // Freeze raised during COMMIT: the commit still completes
      s_hum = 8'd240; s_temp = 8'd0; s_magx = 8'd0; s_magy = 8'd0; s_magz = 8'd0;
      sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      freeze = 1'b1;
      @(negedge clk);
      checkOutput("count_commit_under_freeze", count, 6);
      sample_valid = 1'b1;
      for (int j = 0; j < 3; j++) begin
         checkOutput("freeze_ready", sample_ready, 0);
         @(negedge clk);
         checkOutput("freeze_count", count, 6);
      end
      applyStimulus("freeze_lookup", 5, 7, 5'b00001, 6'b000001);
      applyStimulus("freeze_unpop", 6, 7, 5'b11111, 6'b000000);
      drain();

      // clear with sample_valid held: empties history, nothing accepted
      freeze = 1'b0;
      clear = 1'b1;
      #1 checkOutput("clear_ready", sample_ready, 0);
      @(negedge clk);
      clear = 1'b0;
      sample_valid = 1'b0;
      checkOutput("clear_count", count, 0);
      applyStimulus("clear_lookup", 0, 27, 5'b11111, 6'b000000);
      drain();

      // clear during COMMIT discards the pending write
      sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      checkOutput("clear_discard_count", count, 0);
      applyStimulus("clear_discard_lookup", 0, 7, 5'b11111, 6'b000000);
      drain();

      // 70 sets, hum = 2i: wraps, oldest (set 6) at column 0
      for (int i = 0; i < 70; i++) begin
         pushSet(2 * i, 0, 0, 0, 0);
      end
      checkOutput("count_full", count, 64);
      applyStimulus("wrap_col0", 0, 121, 5'b00001, 6'b000001);
      applyStimulus("wrap_col63", 63, 58, 5'b00001, 6'b000001);
      applyStimulus("wrap_col0_miss", 0, 58, 5'b00001, 6'b000000);
      applyStimulus("wrap_col63_miss", 63, 121, 5'b00001, 6'b000000);
      applyStimulus("wrap_col32", 32, 89, 5'b00001, 6'b000001);
      applyStimulus("wrap_grid_hit", 25, 96, 5'b00001, 6'b100001);
      applyStimulus("wrap_grid", 10, 96, 5'b00001, 6'b100000);
      drain();

      // One more overwrites set 7's predecessor: now column c holds set c+7
      pushSet(140, 0, 0, 0, 0);
      checkOutput("count_saturated", count, 64);

      // Back-to-back lookups, differing cols/rows
      applyStimulus("b2b_0", 0, 120, 5'b00001, 6'b000001);
      applyStimulus("b2b_1", 63, 57, 5'b00001, 6'b000001);
      applyStimulus("b2b_2", 1, 119, 5'b00001, 6'b000001);
      applyStimulus("b2b_3", 5, 0, 5'b00001, 6'b100000);
      applyStimulus("b2b_4", 2, 118, 5'b00000, 6'b000000);
      applyStimulus("b2b_5", 62, 58, 5'b00001, 6'b000001);
      applyStimulus("b2b_6", 3, 127, 5'b11111, 6'b111110);
      applyStimulus("b2b_7", 24, 96, 5'b00001, 6'b100001);
      drain();

      // Reset pulsed mid-stream: outputs drop immediately
      applyStimulus("pre_rst_0", 0, 120, 5'b00001, 6'b000001);
      applyStimulus("pre_rst_1", 1, 119, 5'b00001, 6'b000001);
      applyStimulus("pre_rst_2", 2, 118, 5'b00001, 6'b000001);
      px_req = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midrst_px_valid", px_valid, 0);
      checkOutput("midrst_px_code", px_code, 0);
      checkOutput("midrst_ready", sample_ready, 0);
      checkOutput("midrst_count", count, 0);
      sb.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Reset during COMMIT aborts the write
      s_hum = 8'd200; s_temp = 8'd0; s_magx = 8'd0; s_magy = 8'd0; s_magz = 8'd0;
      sample_valid = 1'b1;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 checkOutput("commit_rst_count", count, 0);
      sample_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("commit_rst_count_after", count, 0);
      applyStimulus("commit_rst_lookup", 0, 27, 5'b00001, 6'b000000);
      drain();

      // A commit on the sampling edge is not visible to that request
      sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      applyStimulus("same_edge_hidden", 0, 27, 5'b00001, 6'b000000);
      applyStimulus("same_edge_after", 0, 27, 5'b00001, 6'b000001);
      drain();
      checkOutput("final_count", count, 1);

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
